// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared constants and types for the memory-port arbiter.
//   - RISCV_ADDR_WIDTH / RISCV_WORD_WIDTH : core address and data widths
//   - arb_state_e : arbiter FSM encoding (registered 2-bit value)
//   - BURST_W / BURST_SAT : width and saturation value of the data burst counter
package mem_arbiter_pkg;

   localparam int RISCV_ADDR_WIDTH = 32;
   localparam int RISCV_WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      MEM_ARB_IDLE  = 2'd0,
      MEM_ARB_GNT_I = 2'd1,
      MEM_ARB_GNT_D = 2'd2
   } arb_state_e;

   localparam int             BURST_W   = 4;
   localparam logic [BURST_W-1:0] BURST_SAT = 4'd15;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one 32-bit memory port between the instruction-fetch requester
//   (i_*) and the load/store requester (d_*). One owner per transaction;
//   data wins ties. With MEM_ARB_STARVE_GUARD_EN defined, a burst counter
//   forces an instruction grant after MAX_DATA_BURST consecutive data
//   grants taken while a fetch was waiting.
//
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     i_valid_i / i_ready_o        fetch request / completion
//     i_addr_i                     fetch address
//     i_wdata_i, i_we_i            unused (fetch never writes)
//     i_rdata_o                    fetch read data (0 unless i_ready_o)
//     d_valid_i / d_ready_o        data request / completion
//     d_addr_i, d_wdata_i, d_we_i  data address, write data, byte enables
//     d_rdata_o                    data read data (0 unless d_ready_o)
//     mem_valid_o / mem_ready_i    memory request / completion
//     mem_addr_o, mem_wdata_o,
//     mem_we_o, mem_rdata_i        memory request fields and read data
//
//   Build option: MEM_ARB_STARVE_GUARD_EN (undefined: no counter, data
//   always wins ties, MAX_DATA_BURST unused).
//
//   state          | meaning
//   ---------------+-----------------------------------------------------
//   MEM_ARB_IDLE   | arbitration cycle, memory port quiet
//   MEM_ARB_GNT_I  | fetch owns the port, fields pass through unlatched
//   MEM_ARB_GNT_D  | data side owns the port, fields pass through unlatched
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_DATA_BURST = 4
) (
   input  logic                        clk,
   input  logic                        rst,

   input  logic                        i_valid_i,
   output logic                        i_ready_o,
   input  logic [RISCV_ADDR_WIDTH-1:0] i_addr_i,
   input  logic [RISCV_WORD_WIDTH-1:0] i_wdata_i,
   input  logic [3:0]                  i_we_i,
   output logic [RISCV_WORD_WIDTH-1:0] i_rdata_o,

   input  logic                        d_valid_i,
   output logic                        d_ready_o,
   input  logic [RISCV_ADDR_WIDTH-1:0] d_addr_i,
   input  logic [RISCV_WORD_WIDTH-1:0] d_wdata_i,
   input  logic [3:0]                  d_we_i,
   output logic [RISCV_WORD_WIDTH-1:0] d_rdata_o,

   output logic                        mem_valid_o,
   input  logic                        mem_ready_i,
   output logic [RISCV_ADDR_WIDTH-1:0] mem_addr_o,
   output logic [RISCV_WORD_WIDTH-1:0] mem_wdata_o,
   output logic [3:0]                  mem_we_o,
   input  logic [RISCV_WORD_WIDTH-1:0] mem_rdata_i
);

   arb_state_e state_q, state_d;
   logic       i_done;
   logic       d_done;
   logic       force_i;

   // Fetch write fields exist only for interface symmetry.
   logic unused_i_fields;
   assign unused_i_fields = ^{i_wdata_i, i_we_i};

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [BURST_W-1:0] burst_q, burst_d;

   assign force_i = (burst_q >= BURST_W'(MAX_DATA_BURST));

   // Counts data grants that completed while a fetch was waiting; any fetch
   // completion, or a data completion with no fetch waiting, restarts it.
   always_comb begin
      burst_d = burst_q;
      if (i_done) begin
         burst_d = '0;
      end else if (d_done) begin
         if (!i_valid_i) begin
            burst_d = '0;
         end else if (burst_q != BURST_SAT) begin
            burst_d = burst_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         burst_q <= '0;
      end else begin
         burst_q <= burst_d;
      end
   end
`else
   logic [BURST_W-1:0] unused_burst_cfg;
   assign force_i          = 1'b0;
   assign unused_burst_cfg = BURST_W'(MAX_DATA_BURST);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MEM_ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs are forced quiet while rst is high so a grant interrupted by
   // reset can never produce a late ready pulse.
   always_comb begin
      state_d     = state_q;
      mem_valid_o = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_we_o    = 4'h0;
      i_ready_o   = 1'b0;
      d_ready_o   = 1'b0;
      i_rdata_o   = '0;
      d_rdata_o   = '0;
      i_done      = 1'b0;
      d_done      = 1'b0;

      if (!rst) begin
         case (state_q)
            MEM_ARB_IDLE: begin
               if (i_valid_i && (!d_valid_i || force_i)) begin
                  state_d = MEM_ARB_GNT_I;
               end else if (d_valid_i) begin
                  state_d = MEM_ARB_GNT_D;
               end
            end

            MEM_ARB_GNT_I: begin
               mem_valid_o = i_valid_i;
               mem_addr_o  = i_addr_i;
               i_done      = i_valid_i && mem_ready_i;
               i_ready_o   = i_done;
               if (i_done) begin
                  i_rdata_o = mem_rdata_i;
               end
               // Completion or abort both hand the port back.
               if (!i_valid_i || mem_ready_i) begin
                  state_d = MEM_ARB_IDLE;
               end
            end

            MEM_ARB_GNT_D: begin
               mem_valid_o = d_valid_i;
               mem_addr_o  = d_addr_i;
               mem_wdata_o = d_wdata_i;
               mem_we_o    = d_we_i;
               d_done      = d_valid_i && mem_ready_i;
               d_ready_o   = d_done;
               if (d_done) begin
                  d_rdata_o = mem_rdata_i;
               end
               if (!d_valid_i || mem_ready_i) begin
                  state_d = MEM_ARB_IDLE;
               end
            end

            default: begin
               state_d = MEM_ARB_IDLE;
            end
         endcase
      end
   end

endmodule
